gcm_aes_input_sequencer: RTL and testbench
==========================================

Name: gcm_aes_input_sequencer

Overview:
Front-end sequencer that sits directly upstream of the gcm_aes pipeline top and drives its per-cycle inputs. It accepts one GCM job descriptor (key, IV, AAD and plaintext bit lengths) and then a stream of 128-bit data blocks under valid/ready. It emits a registered beat stream with the new-instance and plaintext-instance flags, the block data, and the instance sizes. It also zero-pads partial final blocks.

Parameters:
LEN_W, 64, width of each bit-length field (len(A), len(P)).
BLOCK_W, 128, data block width in bits.
INSTANCE_GAP, 0, minimum idle cycles after an instance's last beat before the next job is accepted (0..15).

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
i_job_valid  in  1  job descriptor valid
o_job_ready  out  1  job descriptor accepted when high with i_job_valid
i_cipher_key  in  128  AES-128 key [0:127], bit 0 MSB
i_iv  in  128  IV [0:127]
i_aad_size  in  LEN_W  AAD length in bits [0:63], must be a byte multiple
i_plain_text_size  in  LEN_W  plaintext length in bits, must be a byte multiple
i_data_valid  in  1  data block valid
o_data_ready  out  1  data block accepted when high with i_data_valid
i_data  in  BLOCK_W  AAD or plaintext block; byte k = bits [8k:8k+7]
o_valid  out  1  beat valid
o_new_instance  out  1  first beat of an instance
o_pt_instance  out  1  beat carries plaintext
o_last  out  1  final beat of an instance
o_cipher_key  out  128  captured key, held for the whole instance
o_iv  out  128  captured IV, held for the whole instance
o_aad  out  128  masked AAD block; zero on plaintext beats
o_plain_text  out  128  masked plaintext block; zero on AAD beats
o_aad_size  out  LEN_W  captured AAD bit length
o_plain_text_size  out  LEN_W  captured plaintext bit length
o_busy  out  1  state != IDLE or gap counter nonzero
o_err  out  1  one-cycle pulse on rejected job

Behaviour:
- Reset: on rst_n=0 at a clock edge, all outputs go to 0, state=IDLE, counters=0. o_job_ready=1 on the first cycle after reset. A reset mid-instance discards the instance and emits no further beats.
- States are IDLE, AAD, PT and EMPTY.
- IDLE:
  - o_job_ready = (gap_cnt==0). o_data_ready=0.
  - On job handshake, capture key, IV and both sizes. Compute aad_blk = (aad_size+127)>>7 and pt_blk = (pt_size+127)>>7, each 57-bit.
  - Next state is AAD if aad_blk>0, else PT if pt_blk>0, else EMPTY.
- Size error: if either size has bits [61:63] nonzero, the job is rejected. o_err pulses the next cycle, nothing is captured, and the state stays IDLE.
- AAD and PT states:
  - o_data_ready=1, o_job_ready=0.
  - Each data handshake produces exactly one output beat on the next cycle (latency 1, registered).
  - The counter decrements per handshake. On the last AAD block go to PT if pt_blk>0, else IDLE. On the last PT block go to IDLE.
- EMPTY state (both sizes 0): consumes no data. Emits one beat with o_valid=1, o_new_instance=1, o_pt_instance=0, o_last=1 and zero data, then goes to IDLE.
- Beat flags:
  - o_new_instance=1 only on the first beat of an instance.
  - o_pt_instance=1 on PT beats.
  - o_last=1 on the final beat overall.
- Stall: a cycle without a data handshake gives o_valid=0, all flags 0 and data 0. Key, IV and sizes hold their values.
- Masking applies only to the final AAD block and the final PT block, and only when size[57:63]!=0. With n = size[57:63]>>3 bytes, bytes 0..n-1 pass and bytes n..15 are forced to 0.
- Gap: o_last loads gap_cnt=INSTANCE_GAP, which decrements each cycle. A job handshake is allowed only when gap_cnt==0.
- i_data presented while o_data_ready=0 is ignored.

Decomposition:
- gcm_pkg holds:
  - BLOCK_W=128 and LEN_W=64.
  - typedef seq_state_t {IDLE, AAD, PT, EMPTY}.
  - typedef blk_cnt_t, logic [56:0].
- One sub-module, gcm_block_mask: combinational, takes a 128-bit block and a 4-bit valid-byte count (0 meaning all 16 valid) and returns the masked block. It is reused later by the tag/output stage.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles, release → all outputs 0 and o_job_ready=1. Then assert rst_n=0 mid-PT → no further o_valid, state IDLE.
- Two-block plaintext job: job aad=128, pt=256, then data D0,D1,D2 back-to-back → beats:
  - beat 1: o_aad=D0, new_instance=1, pt_instance=0.
  - beats 2–3: o_plain_text=D1, D2 with pt_instance=1.
  - beat 3 has o_last=1.
  - sizes on every beat: 0x80 and 0x100.
- Partial AAD, no plaintext: aad=40, pt=0, data all 0xFF → one beat o_aad=0xFFFFFFFFFF followed by 88 zero bits, new_instance=1, last=1; then IDLE.
- Empty job: aad=0, pt=0 → exactly one beat with new_instance=1, last=1, zero data; o_data_ready never high.
- Stalls: aad=0, pt=384, i_data_valid toggling 1,0,0,1,0,1 → 3 beats on the cycle after each handshake, o_valid=0 elsewhere, last on the third beat.
- Gap and error: with INSTANCE_GAP=2, o_job_ready is low for exactly 2 cycles after the o_last beat. A job with pt_size=12 → o_err one cycle, no beats, o_busy=0.

Source files
------------

// File: rtl/gcm_pkg.sv
// gcm_pkg: shared widths, sequencer state encoding and block-count type for the GCM front end
package gcm_pkg;
    localparam int BLOCK_W = 128;
    localparam int LEN_W   = 64;
    typedef enum logic [1:0] {IDLE, AAD, PT, EMPTY} seq_state_t;
    typedef logic [56:0] blk_cnt_t;
endpackage

// File: rtl/gcm_block_mask.sv
// gcm_block_mask: keeps the first i_nbytes bytes of a block (byte 0 = MSB), zeroes the rest; 0 keeps all 16
module gcm_block_mask
    import gcm_pkg::*;
(
    input  logic [BLOCK_W-1:0] i_block,
    input  logic [3:0]         i_nbytes,
    output logic [BLOCK_W-1:0] o_block
);
    genvar k;
    for (k = 0; k < BLOCK_W / 8; k++) begin : g_byte
        assign o_block[BLOCK_W-1-8*k -: 8] =
            (i_nbytes == 4'd0 || 4'(k) < i_nbytes) ? i_block[BLOCK_W-1-8*k -: 8] : 8'h00;
    end
endmodule

// File: rtl/gcm_aes_input_sequencer.sv
// gcm_aes_input_sequencer: captures one GCM job descriptor, then turns AAD/PT data blocks into
// registered, tail-masked beats for the gcm_aes pipeline.
module gcm_aes_input_sequencer #(
    parameter int LEN_W        = gcm_pkg::LEN_W,
    parameter int BLOCK_W      = gcm_pkg::BLOCK_W,
    parameter int INSTANCE_GAP = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_job_valid,
    output logic               o_job_ready,
    input  logic [127:0]       i_cipher_key,
    input  logic [127:0]       i_iv,
    input  logic [LEN_W-1:0]   i_aad_size,
    input  logic [LEN_W-1:0]   i_plain_text_size,
    input  logic               i_data_valid,
    output logic               o_data_ready,
    input  logic [BLOCK_W-1:0] i_data,
    output logic               o_valid,
    output logic               o_new_instance,
    output logic               o_pt_instance,
    output logic               o_last,
    output logic [127:0]       o_cipher_key,
    output logic [127:0]       o_iv,
    output logic [BLOCK_W-1:0] o_aad,
    output logic [BLOCK_W-1:0] o_plain_text,
    output logic [LEN_W-1:0]   o_aad_size,
    output logic [LEN_W-1:0]   o_plain_text_size,
    output logic               o_busy,
    output logic               o_err
);
    import gcm_pkg::*;
    seq_state_t         state_q;
    blk_cnt_t           aad_cnt_q, pt_cnt_q;
    logic [3:0]         gap_q;
    logic               first_q, valid_q, new_q, pti_q, last_q, err_q;
    logic [127:0]       key_q, iv_q;
    logic [LEN_W-1:0]   aad_size_q, pt_size_q;
    logic [BLOCK_W-1:0] aad_q, pt_q, blk_d;
    blk_cnt_t           aad_blk_d, pt_blk_d;
    logic               job_hs, data_hs, size_err, in_aad, blk_last, beat_last;
    logic [3:0]         mask_n;
    assign o_job_ready  = state_q == IDLE && gap_q == 4'd0;
    assign o_data_ready = state_q == AAD || state_q == PT;
    assign o_busy       = state_q != IDLE || gap_q != 4'd0;
    assign job_hs       = i_job_valid && o_job_ready;
    assign data_hs      = i_data_valid && o_data_ready;
    assign size_err     = |i_aad_size[2:0] || |i_plain_text_size[2:0];
    assign aad_blk_d    = blk_cnt_t'(i_aad_size >> 7) + blk_cnt_t'(|i_aad_size[6:0]);
    assign pt_blk_d     = blk_cnt_t'(i_plain_text_size >> 7) + blk_cnt_t'(|i_plain_text_size[6:0]);
    assign in_aad       = state_q == AAD;
    assign blk_last     = in_aad ? aad_cnt_q == 57'd1 : pt_cnt_q == 57'd1;
    assign beat_last    = in_aad ? blk_last && pt_cnt_q == '0 : blk_last;
    // Only the final block of a segment can be partial; a zero count keeps the full block.
    assign mask_n       = !blk_last ? 4'd0 : in_aad ? aad_size_q[6:3] : pt_size_q[6:3];
    gcm_block_mask u_mask (
        .i_block  (i_data),
        .i_nbytes (mask_n),
        .o_block  (blk_d)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            aad_cnt_q  <= '0;
            pt_cnt_q   <= '0;
            gap_q      <= '0;
            first_q    <= 1'b0;
            valid_q    <= 1'b0;
            new_q      <= 1'b0;
            pti_q      <= 1'b0;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
            key_q      <= '0;
            iv_q       <= '0;
            aad_size_q <= '0;
            pt_size_q  <= '0;
            aad_q      <= '0;
            pt_q       <= '0;
        end else begin
            valid_q <= 1'b0;
            new_q   <= 1'b0;
            pti_q   <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            aad_q   <= '0;
            pt_q    <= '0;
            if (gap_q != 4'd0) gap_q <= gap_q - 4'd1;
            case (state_q)
                IDLE: if (job_hs) begin
                    if (size_err) err_q <= 1'b1;
                    else begin
                        key_q      <= i_cipher_key;
                        iv_q       <= i_iv;
                        aad_size_q <= i_aad_size;
                        pt_size_q  <= i_plain_text_size;
                        aad_cnt_q  <= aad_blk_d;
                        pt_cnt_q   <= pt_blk_d;
                        first_q    <= 1'b1;
                        state_q    <= aad_blk_d != '0 ? AAD : pt_blk_d != '0 ? PT : EMPTY;
                    end
                end
                EMPTY: begin
                    valid_q <= 1'b1;
                    new_q   <= 1'b1;
                    last_q  <= 1'b1;
                    first_q <= 1'b0;
                    gap_q   <= 4'(INSTANCE_GAP);
                    state_q <= IDLE;
                end
                default: if (data_hs) begin
                    valid_q <= 1'b1;
                    new_q   <= first_q;
                    first_q <= 1'b0;
                    pti_q   <= !in_aad;
                    last_q  <= beat_last;
                    if (in_aad) aad_q <= blk_d;
                    else pt_q <= blk_d;
                    if (in_aad) aad_cnt_q <= aad_cnt_q - 57'd1;
                    else pt_cnt_q <= pt_cnt_q - 57'd1;
                    if (beat_last) gap_q <= 4'(INSTANCE_GAP);
                    if (blk_last) state_q <= in_aad && pt_cnt_q != '0 ? PT : IDLE;
                end
            endcase
        end
    end
    assign o_valid           = valid_q;
    assign o_new_instance    = new_q;
    assign o_pt_instance     = pti_q;
    assign o_last            = last_q;
    assign o_cipher_key      = key_q;
    assign o_iv              = iv_q;
    assign o_aad             = aad_q;
    assign o_plain_text      = pt_q;
    assign o_aad_size        = aad_size_q;
    assign o_plain_text_size = pt_size_q;
    assign o_err             = err_q;
endmodule

// File: tb/tb_gcm_aes_input_sequencer.sv
// tb_gcm_aes_input_sequencer: directed jobs with hand-computed beats queued as they are issued;
// a negedge monitor pops and compares every beat the sequencer emits.
module tb_gcm_aes_input_sequencer;
    logic         clk = 1'b0, rst_n = 1'b0;
    logic         i_job_valid = 1'b0, i_data_valid = 1'b0;
    logic [127:0] i_cipher_key = '0, i_iv = '0, i_data = '0;
    logic [63:0]  i_aad_size = '0, i_plain_text_size = '0;
    logic         o_job_ready, o_data_ready, o_valid, o_new_instance, o_pt_instance, o_last, o_busy, o_err;
    logic [127:0] o_cipher_key, o_iv, o_aad, o_plain_text;
    logic [63:0]  o_aad_size, o_plain_text_size;

    always #5 clk = ~clk;

    gcm_aes_input_sequencer #(.LEN_W(64), .BLOCK_W(128), .INSTANCE_GAP(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_job_valid(i_job_valid), .o_job_ready(o_job_ready),
        .i_cipher_key(i_cipher_key), .i_iv(i_iv),
        .i_aad_size(i_aad_size), .i_plain_text_size(i_plain_text_size),
        .i_data_valid(i_data_valid), .o_data_ready(o_data_ready), .i_data(i_data),
        .o_valid(o_valid), .o_new_instance(o_new_instance), .o_pt_instance(o_pt_instance),
        .o_last(o_last), .o_cipher_key(o_cipher_key), .o_iv(o_iv),
        .o_aad(o_aad), .o_plain_text(o_plain_text),
        .o_aad_size(o_aad_size), .o_plain_text_size(o_plain_text_size),
        .o_busy(o_busy), .o_err(o_err)
    );

    typedef struct {
        int           due;
        logic         nw, pti, lst;
        logic [127:0] aad, pt;
    } beat_t;
    beat_t        q[$];
    int           vectors = 0, miscompares = 0, ncyc = 0;
    logic [127:0] exp_key = '0, exp_iv = '0;
    logic [63:0]  exp_asz = '0, exp_psz = '0;

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        beat_t b;
        ncyc++;
        if (o_valid) begin
            if (q.size() == 0) check("unexpected_beat", 128'(o_valid), 128'(0));
            else begin
                b = q.pop_front();
                check("beat_cycle", 128'(ncyc), 128'(b.due));
                check("new_instance", 128'(o_new_instance), 128'(b.nw));
                check("pt_instance", 128'(o_pt_instance), 128'(b.pti));
                check("last", 128'(o_last), 128'(b.lst));
                check("aad", o_aad, b.aad);
                check("plain_text", o_plain_text, b.pt);
                check("key", o_cipher_key, exp_key);
                check("iv", o_iv, exp_iv);
                check("aad_size", 128'(o_aad_size), 128'(exp_asz));
                check("pt_size", 128'(o_plain_text_size), 128'(exp_psz));
            end
        end
    end

    task automatic job(input logic [63:0] asz, input logic [63:0] psz, input logic [127:0] key, input logic [127:0] iv);
        int n = 0;
        @(negedge clk);
        while (!o_job_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("job_ready_wait", 128'(o_job_ready), 128'(1));
        i_job_valid = 1'b1;
        i_aad_size = asz;
        i_plain_text_size = psz;
        i_cipher_key = key;
        i_iv = iv;
        @(posedge clk);
        #1 i_job_valid = 1'b0;
        if (asz[2:0] == 3'd0 && psz[2:0] == 3'd0) begin
            exp_key = key;
            exp_iv = iv;
            exp_asz = asz;
            exp_psz = psz;
            if (asz == 64'd0 && psz == 64'd0)
                q.push_back('{due: ncyc + 2, nw: 1'b1, pti: 1'b0, lst: 1'b1, aad: '0, pt: '0});
        end
    endtask

    task automatic send(input logic [127:0] d, input logic nw, input logic pti, input logic lst,
                        input logic [127:0] ea, input logic [127:0] ep);
        int n = 0;
        logic rdy;
        @(negedge clk);
        i_data_valid = 1'b1;
        i_data = d;
        while (!o_data_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        rdy = o_data_ready;
        check("data_ready_wait", 128'(rdy), 128'(1));
        @(posedge clk);
        #1 i_data_valid = 1'b0;
        if (rdy) q.push_back('{due: ncyc + 1, nw: nw, pti: pti, lst: lst, aad: ea, pt: ep});
    endtask

    task automatic gap_check();
        int lows = 0;
        @(negedge clk);
        while (!o_job_ready && lows < 10) begin
            lows++;
            @(negedge clk);
        end
        check("gap_cycles", 128'(lows), 128'(2));
    endtask

    initial begin
        int highs;
        int k;
        logic hs;
        logic [5:0] pat;
        logic [127:0] sd [3];
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid", 128'(o_valid), 128'(0));
        check("rst_job_ready", 128'(o_job_ready), 128'(1));
        check("rst_data_ready", 128'(o_data_ready), 128'(0));
        check("rst_busy", 128'(o_busy), 128'(0));
        check("rst_err", 128'(o_err), 128'(0));
        check("rst_key", o_cipher_key, 128'(0));
        check("rst_sizes", 128'({o_aad_size, o_plain_text_size}), 128'(0));

        job(64'h80, 64'h100, 128'h000102030405060708090A0B0C0D0E0F, 128'hCAFEBABEDEADBEEF0000000100000002);
        send(128'h11111111222222223333333344444444, 1'b1, 1'b0, 1'b0, 128'h11111111222222223333333344444444, '0);
        send(128'h55555555666666667777777788888888, 1'b0, 1'b1, 1'b0, '0, 128'h55555555666666667777777788888888);
        send(128'h9999999AAAAAAAABBBBBBBBCCCCCCCC0, 1'b0, 1'b1, 1'b1, '0, 128'h9999999AAAAAAAABBBBBBBBCCCCCCCC0);
        gap_check();

        job(64'd40, 64'd0, 128'hFEEDFACE0123456789ABCDEF00112233, 128'h0);
        send({128{1'b1}}, 1'b1, 1'b0, 1'b1, 128'hFFFFFFFFFF0000000000000000000000, '0);
        gap_check();

        job(64'd0, 64'd0, 128'h1, 128'h2);
        highs = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (o_data_ready) highs++;
        end
        check("empty_data_ready", 128'(highs), 128'(0));

        job(64'd0, 64'd384, 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5, 128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A);
        pat = 6'b101001;
        sd[0] = 128'h0F0E0D0C0B0A09080706050403020100;
        sd[1] = 128'h1F1E1D1C1B1A19181716151413121110;
        sd[2] = 128'h2F2E2D2C2B2A29282726252423222120;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            i_data_valid = pat[i];
            i_data = sd[k % 3];
            hs = pat[i] && o_data_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                q.push_back('{due: ncyc + 1, nw: k == 0, pti: 1'b1, lst: k == 2, aad: '0, pt: sd[k % 3]});
                k++;
            end
        end
        i_data_valid = 1'b0;
        check("stall_handshakes", 128'(k), 128'(3));

        job(64'd8, 64'd136, 128'h0102030405060708090A0B0C0D0E0F10, 128'h1);
        send(128'h0123456789ABCDEFFEDCBA9876543210, 1'b1, 1'b0, 1'b0, 128'h01000000000000000000000000000000, '0);
        send(128'h00112233445566778899AABBCCDDEEFF, 1'b0, 1'b1, 1'b0, '0, 128'h00112233445566778899AABBCCDDEEFF);
        send(128'hAABBCCDDEEFF00112233445566778899, 1'b0, 1'b1, 1'b1, '0, 128'hAA000000000000000000000000000000);

        job(64'd0, 64'd12, 128'hDEAD, 128'hBEEF);
        @(negedge clk);
        check("err_pulse", 128'(o_err), 128'(1));
        @(negedge clk);
        check("err_one_cycle", 128'(o_err), 128'(0));
        check("err_busy", 128'(o_busy), 128'(0));
        check("err_key_kept", o_cipher_key, exp_key);

        job(64'd0, 64'd384, 128'h77, 128'h88);
        send(128'hC0C0C0C0C0C0C0C0C0C0C0C0C0C0C0C0, 1'b1, 1'b1, 1'b0, '0, 128'hC0C0C0C0C0C0C0C0C0C0C0C0C0C0C0C0);
        @(negedge clk);
        rst_n = 1'b0;
        i_data_valid = 1'b1;
        i_data = 128'hC1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        i_data_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_job_ready", 128'(o_job_ready), 128'(1));
        check("midrst_busy", 128'(o_busy), 128'(0));
        check("midrst_data_ready", 128'(o_data_ready), 128'(0));
        check("midrst_key", o_cipher_key, 128'(0));

        check("queue_empty", 128'(q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, miscompares so far %0d", miscompares);
        $fatal(1);
    end
endmodule
